mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and its data-memory port. Each port issues one request at a time, and the block grants one transaction at a time. It latches the transaction onto the memory bus, counts the memory latency, then returns read data with a one-cycle acknowledge. It also drives a combined `stall` that holds the PC, IF_ID and downstream pipeline registers while any port is waiting.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: byte address width.
- `MEM_LATENCY`, 2: cycles from the cycle `mem_en` is high to the cycle `mem_rdata` is valid. Legal range is 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; level, held until `if_ack`.
- `if_addr`  in  ADDR_WIDTH  fetch address; read-only port.
- `if_rdata`  out  DATA_WIDTH  fetched instruction; valid when `if_ack` is high, held until the next `if_ack`.
- `if_ack`  out  1  one-cycle pulse marking fetch completion.
- `d_req`  in  1  data request; level, held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  write data.
- `d_rdata`  out  DATA_WIDTH  read data; valid when `d_ack` is high, held until the next `d_ack`.
- `d_ack`  out  1  one-cycle pulse marking data completion; pulses for writes too.
- `mem_en`  out  1  memory access strobe; one cycle per transaction.
- `mem_we`  out  1  memory write enable; qualified by `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `stall`  out  1  combinational: `(if_req & ~if_ack) | (d_req & ~d_ack)`.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** If any request is high, select a winner and latch grant, address, write-enable and write data. Go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** `mem_en` = 1 with the latched signals. Load the counter with `MEM_LATENCY`. Go to WAIT.
- **WAIT.** Decrement the counter each cycle. When the count reaches 1, capture `mem_rdata` into the winner's rdata register (reads only; writes leave it unchanged). Go to RESP.
- **RESP.** Winner's ack = 1 for this cycle. Requests are ignored in this state. Go to IDLE.

Rules:
- Arbitration (default): data beats fetch on simultaneous requests, because the data access belongs to the older instruction.
- Request inputs are ignored after the grant is latched; changes in `addr`, `we` or `wdata` during ISSUE/WAIT/RESP have no effect.
- A request still high in the cycle after its ack is a new request.
- The losing request stays pending. It is considered in the next IDLE cycle.
- `mem_we` is forced to 0 for fetch grants.
- Counter width is 4 bits.

Reset (asynchronous, also mid-transaction):
- State returns to IDLE.
- `mem_en`, `mem_we`, `if_ack`, `d_ack` = 0.
- `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0.
- Counter = 0; last-grant = fetch.
- Any in-flight response is discarded and no ack is issued.
- `stall` follows the requests immediately after reset.

## Timing
- Request first sampled high in IDLE at cycle T.
- `mem_en` high at T+1.
- Read data captured at the end of cycle T+1+`MEM_LATENCY`.
- Ack high at T+2+`MEM_LATENCY`.
- Total latency is `MEM_LATENCY`+2 cycles for both reads and writes.
- Minimum spacing between grants is `MEM_LATENCY`+3 cycles.
- All outputs are registered except `stall` and `busy`, which is decoded from the state register.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, grant the port not granted most recently. The last-grant register updates on each grant and resets to fetch, so data wins the first tie.
- Undefined: fixed priority, data always wins. No last-grant register is built.
- Single requests behave identically in both builds.

## Test plan
- Fetch read, `MEM_LATENCY`=2, `if_addr`=0x40, memory returns 0x2010_0005: `mem_en` high at T+1, `if_ack` high at T+4, `if_rdata`=0x2010_0005, `stall` high for T..T+3.
- Data write, `d_addr`=0x1001_0000, `d_wdata`=0xDEAD_BEEF: one `mem_en` cycle with `mem_we`=1 and matching address/data, `d_ack` at T+4, `d_rdata` unchanged.
- Both requests held high at the same cycle, fixed priority: data acked at T+4 and fetch at T+9. With `ARB_ROUND_ROBIN_EN`, a second tie after that is won by fetch.
- Assert reset in WAIT during a read: all outputs go to 0 asynchronously, no ack follows, and a request reissued after reset completes normally in `MEM_LATENCY`+2 cycles.
- `MEM_LATENCY`=1 and `MEM_LATENCY`=15 with `if_req` held continuously: acks spaced exactly 4 and 18 cycles apart respectively, and `d_addr` changes during WAIT have no effect on `mem_addr`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency memory between fetch and data ports
//
// Purpose: grants one fetch or data transaction at a time onto a single-ported
// memory, waits MEM_LATENCY cycles, then returns read data with a one-cycle ack.
// Drives a combinational pipeline stall while either port is waiting.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the port not granted most recently
//   undefined : fixed priority, data beats fetch
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_req/if_addr             fetch request (level) and address
//   if_rdata/if_ack            fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (level), write flag, address, data
//   d_rdata/d_ack              read data and one-cycle completion pulse
//   mem_en/mem_we              memory strobe (one cycle) and write enable
//   mem_addr/mem_wdata         latched memory address and write data
//   mem_rdata                  memory read data, valid MEM_LATENCY after mem_en
//   busy                       FSM not in IDLE
//   stall                      any port waiting on its ack

module mem_port_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ack,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  stall
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] LATENCY_LOAD = 4'(MEM_LATENCY);

   state_t     state;
   state_t     state_next;
   logic [3:0] count;
   logic       grant_data;   // current transaction belongs to the data port
   logic       op_we;        // current transaction is a write
   logic       pick_data;    // arbitration result for this IDLE cycle
   logic       take_grant;
   logic       capture;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_data;          // most recent grant went to the data port

   // On a tie the port that was not served last wins; a lone request always wins.
   assign pick_data = d_req & (~if_req | ~last_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_data <= 1'b0;
      end else if (take_grant) begin
         last_data <= pick_data;
      end
   end
`else
   // Data access belongs to the older instruction, so it always wins a tie.
   assign pick_data = d_req;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      take_grant = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (if_req | d_req) begin
               take_grant = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            // Counter was loaded with MEM_LATENCY in ISSUE; the cycle it shows 1
            // is exactly MEM_LATENCY cycles after mem_en.
            if (count <= 4'd1) begin
               capture    = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         count      <= 4'd0;
         grant_data <= 1'b0;
         op_we      <= 1'b0;
      end else begin
         // Strobes are registered so they appear in ISSUE and RESP respectively.
         mem_en <= take_grant;
         mem_we <= take_grant & pick_data & d_we;
         if_ack <= capture & ~grant_data;
         d_ack  <= capture & grant_data;

         if (take_grant) begin
            grant_data <= pick_data;
            op_we      <= pick_data & d_we;
            mem_addr   <= pick_data ? d_addr : if_addr;
            if (pick_data) begin
               mem_wdata <= d_wdata;
            end
         end

         if (state == ISSUE) begin
            count <= LATENCY_LOAD;
         end else if (state == WAIT) begin
            count <= count - 4'd1;
         end

         if (capture & ~op_we) begin
            if (grant_data) begin
               d_rdata <= mem_rdata;
            end else begin
               if_rdata <= mem_rdata;
            end
         end
      end
   end

   assign busy  = (state != IDLE);
   assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ack, d_ack, mem_en, mem_we, busy, stall;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .stall(stall)
   );

   // Memory model: data = addr ^ 0x2010_0045, driven only in the single cycle
   // MEM_LATENCY (=2) cycles after mem_en; any other cycle shows a poison value.
   logic [3:0]  mcnt  = 4'd0;
   logic [31:0] maddr = 32'd0;
   always @(posedge clk) begin
      if (mem_en) begin
         mcnt  <= 4'd2;
         maddr <= mem_addr;
      end else if (mcnt != 4'd0) begin
         mcnt <= mcnt - 4'd1;
      end
   end
   assign mem_rdata = (mcnt == 4'd1) ? (maddr ^ 32'h2010_0045) : 32'hBAD0_BAD0;

   // Two more instances for the latency-extreme spacing test.
   logic        sp_rst, sp_req;
   logic [31:0] sp_d_addr;
   logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
   logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy, a_stall;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
   logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy, b_stall;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) dut_l1 (
      .clk(clk), .reset(sp_rst),
      .if_req(sp_req), .if_addr(32'h40), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
      .d_req(1'b0), .d_we(1'b0), .d_addr(sp_d_addr), .d_wdata(32'h0),
      .d_rdata(a_d_rdata), .d_ack(a_d_ack),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(32'h0), .busy(a_busy), .stall(a_stall)
   );

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(15)) dut_l15 (
      .clk(clk), .reset(sp_rst),
      .if_req(sp_req), .if_addr(32'h40), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
      .d_req(1'b0), .d_we(1'b0), .d_addr(sp_d_addr), .d_wdata(32'h0),
      .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(32'h0), .busy(b_busy), .stall(b_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   int l1_t[2];
   int l15_t[2];
   int l1_n, l15_n;
   logic bad1, bad15;

   initial begin
      reset = 1'b1; sp_rst = 1'b1; sp_req = 1'b0; sp_d_addr = 32'h0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
      chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      reset = 1'b0; sp_rst = 1'b0;

      // Fetch read at 0x40
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h40;
      #1 chk("a_stall_T", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("a_mem_en_T1", {31'd0, mem_en}, 32'd1);
      chk("a_mem_we_T1", {31'd0, mem_we}, 32'd0);
      chk("a_mem_addr_T1", mem_addr, 32'h40);
      chk("a_busy_T1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("a_mem_en_T2", {31'd0, mem_en}, 32'd0);
      chk("a_stall_T2", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("a_if_ack_T3", {31'd0, if_ack}, 32'd0);
      chk("a_stall_T3", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("a_if_ack_T4", {31'd0, if_ack}, 32'd1);
      chk("a_if_rdata", if_rdata, 32'h2010_0005);
      chk("a_stall_T4", {31'd0, stall}, 32'd0);
      if_req = 1'b0;
      @(negedge clk);
      chk("a_if_ack_T5", {31'd0, if_ack}, 32'd0);
      chk("a_busy_T5", {31'd0, busy}, 32'd0);

      // Data write, with d_addr/d_wdata changed during WAIT
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("b_mem_en_T1", {31'd0, mem_en}, 32'd1);
      chk("b_mem_we_T1", {31'd0, mem_we}, 32'd1);
      chk("b_mem_addr_T1", mem_addr, 32'h1001_0000);
      chk("b_mem_wdata_T1", mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("b_mem_en_T2", {31'd0, mem_en}, 32'd0);
      chk("b_mem_we_T2", {31'd0, mem_we}, 32'd0);
      d_addr = 32'h5555_0000; d_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("b_mem_addr_T3", mem_addr, 32'h1001_0000);
      chk("b_mem_wdata_T3", mem_wdata, 32'hDEAD_BEEF);
      chk("b_d_ack_T3", {31'd0, d_ack}, 32'd0);
      @(negedge clk);
      chk("b_d_ack_T4", {31'd0, d_ack}, 32'd1);
      chk("b_d_rdata_kept", d_rdata, 32'd0);
      chk("b_if_ack_T4", {31'd0, if_ack}, 32'd0);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("b_d_ack_T5", {31'd0, d_ack}, 32'd0);

      // Simultaneous requests: data first, fetch after
      d_req = 1'b1; d_addr = 32'h200; if_req = 1'b1; if_addr = 32'h80;
      @(negedge clk);
      chk("c_mem_en_T1", {31'd0, mem_en}, 32'd1);
      chk("c_mem_addr_T1", mem_addr, 32'h200);
      cyc(3);
      chk("c_d_ack_T4", {31'd0, d_ack}, 32'd1);
      chk("c_if_ack_T4", {31'd0, if_ack}, 32'd0);
      chk("c_d_rdata", d_rdata, 32'h2010_0245);
      chk("c_stall_T4", {31'd0, stall}, 32'd1);
      d_req = 1'b0;
      @(negedge clk);
      chk("c_busy_T5", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("c_mem_en_T6", {31'd0, mem_en}, 32'd1);
      chk("c_mem_addr_T6", mem_addr, 32'h80);
      cyc(3);
      chk("c_if_ack_T9", {31'd0, if_ack}, 32'd1);
      chk("c_if_rdata", if_rdata, 32'h2010_00C5);
      if_req = 1'b0;
      @(negedge clk);

      // Tie, then data re-requests immediately after its ack: second tie
      d_req = 1'b1; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'hC0;
      @(negedge clk);
      chk("d_mem_addr_T1", mem_addr, 32'h100);
      cyc(3);
      chk("d_d_ack_T4", {31'd0, d_ack}, 32'd1);
      d_addr = 32'h300;
      cyc(2);
      chk("d_mem_en_T6", {31'd0, mem_en}, 32'd1);
`ifdef ARB_ROUND_ROBIN_EN
      chk("d_tie2_winner", mem_addr, 32'hC0);
`else
      chk("d_tie2_winner", mem_addr, 32'h300);
`endif
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if_ack) if_req = 1'b0;
         if (d_ack) d_req = 1'b0;
         if (!if_req && !d_req) break;
      end
      chk("d_drained", {30'd0, if_req, d_req}, 32'd0);
      @(negedge clk);

      // Reset during WAIT of a read, then the held request completes normally
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      cyc(2);
      chk("e_busy_wait", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("e_busy_rst", {31'd0, busy}, 32'd0);
      chk("e_mem_addr_rst", mem_addr, 32'd0);
      chk("e_mem_wdata_rst", mem_wdata, 32'd0);
      chk("e_if_rdata_rst", if_rdata, 32'd0);
      chk("e_d_rdata_rst", d_rdata, 32'd0);
      chk("e_stall_rst", {31'd0, stall}, 32'd1);
      @(negedge clk);
      chk("e_d_ack_rst", {31'd0, d_ack}, 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("e_d_ack_k%0d", k), {31'd0, d_ack}, (k == 4) ? 32'd1 : 32'd0);
      end
      chk("e_d_rdata", d_rdata, 32'h2010_0445);
      d_req = 1'b0;
      @(negedge clk);

      // Spacing with MEM_LATENCY=1 and 15, fetch held, d_addr wandering
      l1_t = '{0, 0}; l15_t = '{0, 0}; l1_n = 0; l15_n = 0; bad1 = 1'b0; bad15 = 1'b0;
      sp_req = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (a_if_ack && l1_n < 2) begin l1_t[l1_n] = k; l1_n++; end
         if (b_if_ack && l15_n < 2) begin l15_t[l15_n] = k; l15_n++; end
         if (a_busy && a_mem_addr !== 32'h40) bad1 = 1'b1;
         if (b_busy && b_mem_addr !== 32'h40) bad15 = 1'b1;
         sp_d_addr = $urandom;
      end
      sp_req = 1'b0;
      chk("f_l1_first", l1_t[0], 32'd3);
      chk("f_l1_spacing", l1_t[1] - l1_t[0], 32'd4);
      chk("f_l15_first", l15_t[0], 32'd17);
      chk("f_l15_spacing", l15_t[1] - l15_t[0], 32'd18);
      chk("f_l1_addr_stable", {31'd0, bad1}, 32'd0);
      chk("f_l15_addr_stable", {31'd0, bad15}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
